// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU operand-issue stage.
//   WORD_SIZE      datapath and register width
//   ALU_* opcodes  values carried on alu_op
//   *_LSB          instruction field positions
//   state_e        issue FSM encoding
package alu_issue_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned REG_AW    = 3;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_MUL   = 4'd2;
    localparam logic [3:0] ALU_DIV   = 4'd3;
    localparam logic [3:0] ALU_SLT   = 4'd4;
    localparam logic [3:0] ALU_AND   = 4'd5;
    localparam logic [3:0] ALU_OR    = 4'd6;
    localparam logic [3:0] ALU_XOR   = 4'd7;
    localparam logic [3:0] ALU_SHIFT = 4'd8;

    localparam int unsigned OP_LSB      = 12;
    localparam int unsigned RD_LSB      = 9;
    localparam int unsigned RS1_LSB     = 6;
    localparam int unsigned IMM_SEL_BIT = 5;
    localparam int unsigned RS2_LSB     = 2;
    localparam int unsigned IMM_W       = 5;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWait,
        StWb
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= ALU_SHIFT;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction, ALU and writeback signals of the issue stage.
//   master: the issue stage (takes instr/instr_valid/alu_out, drives the rest)
//   slave:  the surrounding instruction source, ALU and writeback sink
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic [INSTR_W-1:0]   instr;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [3:0]           alu_op;
    logic [WORD_SIZE-1:0] alu_in1;
    logic [WORD_SIZE-1:0] alu_in2;
    logic                 alu_en;
    logic [WORD_SIZE-1:0] alu_out;
    logic                 wb_valid;
    logic [REG_AW-1:0]    wb_rd;
    logic [WORD_SIZE-1:0] wb_data;
    logic                 err_illegal;
    logic                 err_div0;

    modport master (
        input  instr, instr_valid, alu_out,
        output instr_ready, alu_op, alu_in1, alu_in2, alu_en,
               wb_valid, wb_rd, wb_data, err_illegal, err_div0
    );

    modport slave (
        output instr, instr_valid, alu_out,
        input  instr_ready, alu_op, alu_in1, alu_in2, alu_en,
               wb_valid, wb_rd, wb_data, err_illegal, err_div0
    );

endinterface

// File: rtl/alu_regfile.sv
// NUM_REGS x WORD_SIZE register file with r0 hard-wired to zero.
//   ra1_i/rd1_o, ra2_i/rd2_o  combinational source read ports
//   dbg_addr_i/dbg_data_o     combinational debug read port
//   we_i/wa_i/wd_i            synchronous write port (writes to r0 dropped)
//   rst_n                     asynchronous clear of every entry
module alu_regfile
    import alu_issue_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_AW-1:0]    ra1_i,
    output logic [WORD_SIZE-1:0] rd1_o,
    input  logic [REG_AW-1:0]    ra2_i,
    output logic [WORD_SIZE-1:0] rd2_o,
    input  logic [REG_AW-1:0]    dbg_addr_i,
    output logic [WORD_SIZE-1:0] dbg_data_o,
    input  logic                 we_i,
    input  logic [REG_AW-1:0]    wa_i,
    input  logic [WORD_SIZE-1:0] wd_i
);

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i && (wa_i != '0)) begin
            regs_d[wa_i] = wd_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1_o      = (ra1_i == '0)      ? '0 : regs_q[ra1_i];
    assign rd2_o      = (ra2_i == '0)      ? '0 : regs_q[ra2_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Non-pipelined operand-issue stage in front of the ALU.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         instruction handshake, ALU drive/result, writeback and error pulses
//   dbg_addr    debug read address; dbg_data returns regfile[dbg_addr] (r0 reads 0)
// One instruction in flight: IDLE -> EXEC (alu_en) -> [WAIT] -> WB -> IDLE.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_if.master          bus,
    input  logic [REG_AW-1:0]    dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data
);

    localparam int unsigned CntW = (ALU_LATENCY > 2) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'((ALU_LATENCY > 1) ? ALU_LATENCY - 2 : 0);

    state_e               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [WORD_SIZE-1:0] in1_q, in1_d;
    logic [WORD_SIZE-1:0] in2_q, in2_d;
    logic [REG_AW-1:0]    rd_q, rd_d;
    logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 alu_en_q, alu_en_d;
    logic                 wb_valid_q, wb_valid_d;
    logic                 err_ill_q, err_ill_d;
    logic                 err_div_q, err_div_d;
    logic                 rf_we;

    // Instruction decode.
    logic [3:0]           dec_op;
    logic [REG_AW-1:0]    dec_rd, dec_rs1, dec_rs2;
    logic                 dec_imm_sel;
    logic [WORD_SIZE-1:0] rs1_val, rs2_val, opnd2;

    assign dec_op      = bus.instr[OP_LSB +: 4];
    assign dec_rd      = bus.instr[RD_LSB +: REG_AW];
    assign dec_rs1     = bus.instr[RS1_LSB +: REG_AW];
    assign dec_rs2     = bus.instr[RS2_LSB +: REG_AW];
    assign dec_imm_sel = bus.instr[IMM_SEL_BIT];
    assign opnd2       = dec_imm_sel ? {{(WORD_SIZE - IMM_W){1'b0}}, bus.instr[IMM_W-1:0]}
                                     : rs2_val;

    alu_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra1_i      (dec_rs1),
        .rd1_o      (rs1_val),
        .ra2_i      (dec_rs2),
        .rd2_o      (rs2_val),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (rf_we),
        .wa_i       (rd_q),
        .wd_i       (bus.alu_out)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        cnt_d      = cnt_q;
        alu_en_d   = 1'b0;
        wb_valid_d = 1'b0;
        err_ill_d  = 1'b0;
        err_div_d  = 1'b0;
        rf_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.instr_valid) begin
                    if (!op_is_legal(dec_op)) begin
                        err_ill_d = 1'b1;
                    end else if ((dec_op == ALU_DIV) && (opnd2 == '0)) begin
                        err_div_d = 1'b1;
                    end else begin
                        op_d     = dec_op;
                        in1_d    = rs1_val;
                        in2_d    = opnd2;
                        rd_d     = dec_rd;
                        alu_en_d = 1'b1;
                        state_d  = StExec;
                    end
                end
            end
            StExec: begin
                if (ALU_LATENCY > 1) begin
                    cnt_d   = CntLoad;
                    state_d = StWait;
                end else begin
                    wb_valid_d = 1'b1;
                    state_d    = StWb;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    wb_valid_d = 1'b1;
                    state_d    = StWb;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWb: begin
                rf_we     = 1'b1;
                wb_data_d = bus.alu_out;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            cnt_q      <= '0;
            alu_en_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            err_ill_q  <= 1'b0;
            err_div_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            cnt_q      <= cnt_d;
            alu_en_q   <= alu_en_d;
            wb_valid_q <= wb_valid_d;
            err_ill_q  <= err_ill_d;
            err_div_q  <= err_div_d;
        end
    end

    assign bus.instr_ready = (state_q == StIdle);
    assign bus.alu_op      = op_q;
    assign bus.alu_in1     = in1_q;
    assign bus.alu_in2     = in2_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = rd_q;
    assign bus.err_illegal = err_ill_q;
    assign bus.err_div0    = err_div_q;
    // The ALU result only becomes valid inside WB, so it is passed straight through
    // there; outside WB the last written value is held.
    assign bus.wb_data     = (state_q == StWb) ? bus.alu_out : wb_data_q;

endmodule
